// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receive endpoint. It deserialises MSB-first words
// into an RX FIFO that local logic drains over a valid/ready handshake.
// Optional feature macro: SPI_SLAVE_ECHO_EN (echoes the previous word on miso).
module spi_slave_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sclk,
  input  logic                        sel,
  input  logic                        mosi,
  output logic                        miso,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  output logic                        frame_err
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   sel_prev_q, sel_prev_d;
  logic [DATA_W-1:0]      sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]      fifo_count_q, fifo_count_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  logic sclk_s, sel_s, mosi_s, sclk_fall, sel_fall;
  logic shift_en, cnt_clr, push, pop, full, wr_en;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sel_s     = sel_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign sel_fall  = sel_prev_q & ~sel_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; COMMIT is entered on the same edge that samples the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_s) state_d = SHIFT;
      SHIFT: begin
        if (sel_fall) state_d = IDLE;
        else if (sclk_fall && (cnt_q == CNT_W'(DATA_W - 1))) state_d = COMMIT;
      end
      COMMIT:  state_d = sel_s ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes and the abort indication
  always_comb begin
    shift_en    = 1'b0;
    cnt_clr     = 1'b0;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: cnt_clr = 1'b1;
      SHIFT: begin
        if (sel_fall) begin
          cnt_clr     = 1'b1;
          frame_err_d = (cnt_q != '0);
        end else if (sclk_fall) begin
          shift_en = 1'b1;
        end
      end
      COMMIT: begin
        push    = 1'b1;
        cnt_clr = 1'b1;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Synchronisers, shifter and FIFO next-state; rx_data mirrors the next head entry
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    sel_sync_d  = {sel_sync_q[SYNC_STAGES-2:0], sel};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    sel_prev_d  = sel_s;

    sr_d  = shift_en ? {sr_q[DATA_W-2:0], mosi_s} : sr_q;
    cnt_d = cnt_clr ? '0 : (shift_en ? cnt_q + CNT_W'(1) : cnt_q);

    pop   = rx_valid_q & rx_ready;
    full  = (fifo_count_q == FCNT_W'(FIFO_DEPTH));
    wr_en = push & (~full | pop);

    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = sr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    fifo_count_d = fifo_count_q;
    if (wr_en && !pop)      fifo_count_d = fifo_count_q + FCNT_W'(1);
    else if (!wr_en && pop) fifo_count_d = fifo_count_q - FCNT_W'(1);

    overrun_d  = overrun_q | (push & full & ~pop);
    rx_valid_d = (fifo_count_d != '0);
    rx_data_d  = rx_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      sel_sync_q   <= '0;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      sel_prev_q   <= 1'b0;
      sr_q         <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      sel_sync_q   <= sel_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      sel_prev_q   <= sel_prev_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign fifo_count = fifo_count_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

`ifdef SPI_SLAVE_ECHO_EN
  logic [DATA_W-1:0] echo_q, echo_d;
  logic              miso_q, miso_d;
  logic              sclk_rise;

  assign sclk_rise = ~sclk_prev_q & sclk_s;

  // Echo shifter; the rise before a word's first sample (count 0) must not shift
  always_comb begin
    echo_d = echo_q;
    if (push) echo_d = sr_q;
    else if ((state_q == SHIFT) && sclk_rise && (cnt_q != '0)) echo_d = echo_q << 1;
    miso_d = (state_d == IDLE) ? 1'b0 : echo_d[DATA_W-1];
  end

  // Echo registers
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_q <= '0;
      miso_q <= 1'b0;
    end else begin
      echo_q <= echo_d;
      miso_q <= miso_d;
    end
  end

  assign miso = miso_q;
`else
  assign miso = 1'b0;
`endif

endmodule
